// File: rtl/axi_io_pkg.sv
// Shared types and constants for the AXI-lite to multi-channel IO bridge.
package axi_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/axi_io_bridge_if.sv
// Simplified AXI-lite bus between the CPU master and the IO bridge (single-cycle b/r pulses).
interface axi_io_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic            wvalid;
  logic            wready;
  logic [AW-1:0]   awaddr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            bvalid;
  logic            bresp;
  logic            arvalid;
  logic            arready;
  logic [AW-1:0]   araddr;
  logic            rvalid;
  logic            rresp;
  logic [DW-1:0]   rdata;

  modport master (
    output wvalid, awaddr, wdata, wstrb, arvalid, araddr,
    input  wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );

  modport slave (
    input  wvalid, awaddr, wdata, wstrb, arvalid, araddr,
    output wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );

endinterface

// File: rtl/axi_io_decode.sv
// Combinational address decoder: masked compare against each channel base, lowest index wins.
module axi_io_decode #(
  parameter int                     AW      = 32,
  parameter int                     NUM_CH  = 2,
  parameter logic [NUM_CH*AW-1:0]   CH_BASE = {32'hC000_0100, 32'hC000_0000},
  parameter logic [AW-1:0]          CH_MASK = 32'hFFFF_FF00
) (
  input  logic [AW-1:0]     addr,
  output logic              hit,
  output logic [NUM_CH-1:0] sel
);

  // Priority decode, first matching channel claims the access
  always_comb begin
    hit = 1'b0;
    sel = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (!hit && ((addr & CH_MASK) == CH_BASE[i*AW +: AW])) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end else begin
        sel[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_io_bridge.sv
// AXI-lite to NUM_CH IO channel bridge with registered IO outputs and error responses.
// Optional bus timeout in WAIT is enabled by defining AXI_IO_BRIDGE_TIMEOUT_EN.
module axi_io_bridge
  import axi_io_pkg::*;
#(
  parameter int                     AW       = 32,
  parameter int                     DW       = 32,
  parameter int                     NUM_CH   = 2,
  parameter logic [NUM_CH*AW-1:0]   CH_BASE  = {32'hC000_0100, 32'hC000_0000},
  parameter logic [AW-1:0]          CH_MASK  = 32'hFFFF_FF00,
  parameter logic [DW-1:0]          ERR_DATA = 32'hDEAD_BEEF
`ifdef AXI_IO_BRIDGE_TIMEOUT_EN
  , parameter int                   TIMEOUT  = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_io_bridge_if.slave       bus,
  output logic [NUM_CH-1:0]    io_addr_strobe,
  output logic [NUM_CH-1:0]    io_read_strobe,
  output logic [NUM_CH-1:0]    io_write_strobe,
  output logic [AW-1:0]        io_addr,
  output logic [DW/8-1:0]      io_byte_enable,
  output logic [DW-1:0]        io_write_data,
  input  logic [NUM_CH*DW-1:0] io_read_data,
  input  logic [NUM_CH-1:0]    io_ready
);

  state_e              state_r, state_s;
  logic [AW-1:0]       acc_addr_s;
  logic                hit_s;
  logic [NUM_CH-1:0]   sel_s, sel_r;
  logic                dir_wr_r;
  logic                accept_s, accept_wr_s;
  logic                resp_go_s, resp_wr_s, resp_err_s;
  logic                ready_sel_s;
  logic [DW-1:0]       rd_mux_s;

  logic [NUM_CH-1:0]   io_addr_strobe_r, io_read_strobe_r, io_write_strobe_r;
  logic [AW-1:0]       io_addr_r;
  logic [DW/8-1:0]     io_byte_enable_r;
  logic [DW-1:0]       io_write_data_r;
  logic                bvalid_r, bresp_r, rvalid_r, rresp_r;
  logic [DW-1:0]       rdata_r;

`ifdef AXI_IO_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]         tmo_cnt_r;
`endif

  // Write has priority, so the decoder looks at awaddr whenever wvalid is up
  always_comb begin
    if (bus.wvalid) begin
      acc_addr_s = bus.awaddr;
    end else begin
      acc_addr_s = bus.araddr;
    end
  end

  axi_io_decode #(
    .AW      (AW),
    .NUM_CH  (NUM_CH),
    .CH_BASE (CH_BASE),
    .CH_MASK (CH_MASK)
  ) u_decode (
    .addr (acc_addr_s),
    .hit  (hit_s),
    .sel  (sel_s)
  );

  // Only the selected channel's ready and read data are observed
  always_comb begin
    rd_mux_s = {DW{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_r[i]) begin
        rd_mux_s = rd_mux_s | io_read_data[i*DW +: DW];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
  end

  assign ready_sel_s = |(io_ready & sel_r);
  assign bus.wready  = (state_r == IDLE);
  assign bus.arready = (state_r == IDLE) && !bus.wvalid;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and transaction control
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    accept_wr_s = 1'b0;
    resp_go_s   = 1'b0;
    resp_wr_s   = dir_wr_r;
    resp_err_s  = RESP_OK;
    case (state_r)
      IDLE: begin
        if (bus.wvalid) begin
          accept_s    = 1'b1;
          accept_wr_s = 1'b1;
          resp_wr_s   = 1'b1;
        end else if (bus.arvalid) begin
          accept_s  = 1'b1;
          resp_wr_s = 1'b0;
        end else begin
          accept_s = 1'b0;
        end
        if (accept_s && hit_s) begin
          state_s = ISSUE;
        end else if (accept_s) begin
          state_s    = RESP;
          resp_go_s  = 1'b1;
          resp_err_s = RESP_ERR;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (ready_sel_s) begin
          state_s   = RESP;
          resp_go_s = 1'b1;
        end
`ifdef AXI_IO_BRIDGE_TIMEOUT_EN
        else if (tmo_cnt_r == TMO_LAST) begin
          state_s    = RESP;
          resp_go_s  = 1'b1;
          resp_err_s = RESP_ERR;
        end
`endif
        else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

`ifdef AXI_IO_BRIDGE_TIMEOUT_EN
  // Bus timeout counter, runs only while waiting on the channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_r == ISSUE) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_r == WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`endif

  // Registered IO side and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_addr_strobe_r  <= {NUM_CH{1'b0}};
      io_read_strobe_r  <= {NUM_CH{1'b0}};
      io_write_strobe_r <= {NUM_CH{1'b0}};
      io_addr_r         <= {AW{1'b0}};
      io_byte_enable_r  <= {(DW/8){1'b0}};
      io_write_data_r   <= {DW{1'b0}};
      sel_r             <= {NUM_CH{1'b0}};
      dir_wr_r          <= 1'b0;
      bvalid_r          <= 1'b0;
      bresp_r           <= RESP_OK;
      rvalid_r          <= 1'b0;
      rresp_r           <= RESP_OK;
      rdata_r           <= {DW{1'b0}};
    end else begin
      if (accept_s && hit_s) begin
        io_addr_strobe_r  <= sel_s;
        io_write_strobe_r <= accept_wr_s ? sel_s : {NUM_CH{1'b0}};
        io_read_strobe_r  <= accept_wr_s ? {NUM_CH{1'b0}} : sel_s;
      end else begin
        io_addr_strobe_r  <= {NUM_CH{1'b0}};
        io_write_strobe_r <= {NUM_CH{1'b0}};
        io_read_strobe_r  <= {NUM_CH{1'b0}};
      end
      if (accept_s) begin
        io_addr_r <= acc_addr_s;
        dir_wr_r  <= accept_wr_s;
        sel_r     <= sel_s;
        if (accept_wr_s) begin
          io_byte_enable_r <= bus.wstrb;
          io_write_data_r  <= bus.wdata;
        end else begin
          io_byte_enable_r <= {(DW/8){1'b0}};
          io_write_data_r  <= io_write_data_r;
        end
      end else begin
        io_addr_r <= io_addr_r;
      end
      bvalid_r <= resp_go_s && resp_wr_s;
      rvalid_r <= resp_go_s && !resp_wr_s;
      bresp_r  <= (resp_go_s && resp_wr_s) ? resp_err_s : RESP_OK;
      rresp_r  <= (resp_go_s && !resp_wr_s) ? resp_err_s : RESP_OK;
      if (resp_go_s && !resp_wr_s) begin
        rdata_r <= (resp_err_s == RESP_ERR) ? ERR_DATA : rd_mux_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign io_addr_strobe  = io_addr_strobe_r;
  assign io_read_strobe  = io_read_strobe_r;
  assign io_write_strobe = io_write_strobe_r;
  assign io_addr         = io_addr_r;
  assign io_byte_enable  = io_byte_enable_r;
  assign io_write_data   = io_write_data_r;
  assign bus.bvalid      = bvalid_r;
  assign bus.bresp       = bresp_r;
  assign bus.rvalid      = rvalid_r;
  assign bus.rresp       = rresp_r;
  assign bus.rdata       = rdata_r;

endmodule

// File: tb/tb_axi_io_bridge.sv
// Scoreboard bench for axi_io_bridge: stimulus pushes expected strobes/responses, a monitor pops and compares.
module tb_axi_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0] io_addr, io_write_data;
  logic [3:0]  io_byte_enable;
  logic [63:0] io_read_data;
  logic [1:0]  io_ready;

  always #5 clk = ~clk;

  axi_io_bridge_if #(.AW(32), .DW(32)) bus ();

  axi_io_bridge u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .io_addr_strobe  (io_addr_strobe),
    .io_read_strobe  (io_read_strobe),
    .io_write_strobe (io_write_strobe),
    .io_addr         (io_addr),
    .io_byte_enable  (io_byte_enable),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .io_ready        (io_ready)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  as;
    logic [1:0]  rs;
    logic [1:0]  ws;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } strb_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic        resp;
    logic [31:0] rdata;
  } rsp_t;

  strb_t       sq[$];
  rsp_t        rq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          dly[2];
  int          cnt[2];
  logic [31:0] rdv[2];
  logic [1:0]  rdy_rsp = 2'b00;
  logic [1:0]  rdy_noise = 2'b00;
  logic [31:0] last_rdata = 32'h0;

  assign io_ready     = rdy_rsp | rdy_noise;
  assign io_read_data = {rdv[1], rdv[0]};

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Channel responders: raise io_ready dly cycles after the strobe (0 = never)
  initial begin
    cnt[0] = 0;
    cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rdy_rsp[i] = 1'b0;
        if (!rst_n) begin
          cnt[i] = 0;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) rdy_rsp[i] = 1'b1;
        end
        if (rst_n && io_addr_strobe[i] && dly[i] > 0) cnt[i] = dly[i];
      end
    end
  end

  // Monitor: compare every strobe and every response against the queues
  initial begin
    strb_t se;
    rsp_t  re;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (|{io_addr_strobe, io_read_strobe, io_write_strobe}) begin
          if (sq.size() == 0) begin
            check("unexpected_strobe", {io_addr_strobe, io_read_strobe, io_write_strobe}, 64'h0);
          end else begin
            se = sq.pop_front();
            check("strobe_cycle", cyc, se.cyc);
            check("addr_strobe", io_addr_strobe, se.as);
            check("read_strobe", io_read_strobe, se.rs);
            check("write_strobe", io_write_strobe, se.ws);
            check("io_addr", io_addr, se.addr);
            if (|se.ws) begin
              check("io_byte_enable", io_byte_enable, se.be);
              check("io_write_data", io_write_data, se.wd);
            end
          end
        end
        if (bus.bvalid || bus.rvalid) begin
          if (rq.size() == 0) begin
            check("unexpected_resp", {bus.bvalid, bus.rvalid}, 64'h0);
          end else begin
            re = rq.pop_front();
            check("resp_cycle", cyc, re.cyc);
            check("resp_kind", {bus.bvalid, bus.rvalid}, {re.wr, !re.wr});
            check("bresp", bus.bresp, re.wr ? re.resp : 1'b0);
            check("rresp", bus.rresp, re.wr ? 1'b0 : re.resp);
            check("rdata", bus.rdata, re.rdata);
          end
        end
      end
    end
  end

  // Issue one request; d = channel ready delay (0 = never, no response expected)
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic hit, input int ch, input int d,
                       output int t);
    int n;
    rsp_t r;
    @(posedge clk);
    #1;
    if (wr) begin
      bus.wvalid = 1'b1; bus.awaddr = addr; bus.wdata = wd; bus.wstrb = be;
    end else begin
      bus.arvalid = 1'b1; bus.araddr = addr;
    end
    n = 0;
    @(negedge clk);
    while (!(wr ? bus.wready : bus.arready) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("accept_bound", n, 0);
    t = cyc;
    if (hit) begin
      sq.push_back('{t + 1, 2'(1 << ch), wr ? 2'b00 : 2'(1 << ch), wr ? 2'(1 << ch) : 2'b00,
                     addr, be, wd});
    end
    if (!hit || d > 0) begin
      if (!wr) last_rdata = hit ? rdv[ch] : 32'hDEAD_BEEF;
      r.cyc = hit ? t + d + 2 : t + 1;
      r.wr = wr;
      r.resp = !hit;
      r.rdata = last_rdata;
      rq.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.wvalid = 1'b0;
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("resp_bound", rq.size(), 0);
  endtask

  initial begin
    int t1, t2;
    rsp_t r;
    bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bus.awaddr = 32'h0; bus.araddr = 32'h0; bus.wdata = 32'h0; bus.wstrb = 4'h0;
    dly[0] = 1; dly[1] = 1;
    rdv[0] = 32'h0; rdv[1] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_strobes", {io_addr_strobe, io_read_strobe, io_write_strobe}, 0);
    check("rst_io_addr", io_addr, 0);
    check("rst_byte_enable", io_byte_enable, 0);
    check("rst_write_data", io_write_data, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_wready", bus.wready, 1);
    check("rst_arready", bus.arready, 1);

    // Write ch0, ready after 2 cycles
    dly[0] = 2;
    issue(1'b1, 32'hC000_0004, 32'h1234_5678, 4'hF, 1'b1, 0, 2, t1);
    wait_idle();

    // Read ch1, ready after 1 cycle; ch0 carries different data
    rdv[0] = 32'h5555_AAAA; rdv[1] = 32'hA5A5_0001; dly[1] = 1;
    issue(1'b0, 32'hC000_0108, 32'h0, 4'h0, 1'b1, 1, 1, t1);
    wait_idle();

    // Minimum latency: back-to-back write then read on ch1
    dly[1] = 1; rdv[1] = 32'h0F0F_3C3C;
    issue(1'b1, 32'hC000_01FC, 32'h8765_4321, 4'h3, 1'b1, 1, 1, t1);
    issue(1'b0, 32'hC000_0180, 32'h0, 4'h0, 1'b1, 1, 1, t2);
    check("b2b_accept", t2, t1 + 4);
    wait_idle();

    // Simultaneous write and read: write wins, read follows the write response
    dly[0] = 1; rdv[0] = 32'h1111_2222;
    @(posedge clk);
    #1;
    bus.wvalid = 1'b1; bus.awaddr = 32'hC000_0010; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hC;
    bus.arvalid = 1'b1; bus.araddr = 32'hC000_0020;
    @(negedge clk);
    check("arready_with_wvalid", bus.arready, 0);
    t1 = cyc;
    sq.push_back('{t1 + 1, 2'b01, 2'b00, 2'b01, 32'hC000_0010, 4'hC, 32'hCAFE_F00D});
    rq.push_back('{t1 + 3, 1'b1, 1'b0, last_rdata});
    @(posedge clk);
    #1;
    bus.wvalid = 1'b0;
    t2 = 0;
    @(negedge clk);
    while (!bus.arready && t2 < 50) begin
      t2++;
      @(negedge clk);
    end
    check("read_after_write_accept", cyc, t1 + 4);
    last_rdata = 32'h1111_2222;
    sq.push_back('{cyc + 1, 2'b01, 2'b01, 2'b00, 32'hC000_0020, 4'h0, 32'h0});
    rq.push_back('{cyc + 3, 1'b0, 1'b0, last_rdata});
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    wait_idle();

    // Decode misses: read returns ERR_DATA, write error leaves rdata alone
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, 0, 0, t1);
    wait_idle();
    issue(1'b1, 32'hC000_0200, 32'h0BAD_0BAD, 4'hF, 1'b0, 0, 0, t1);
    wait_idle();

    // Ready on the unselected channel is ignored
    dly[0] = 3; rdv[0] = 32'h0BAD_F00D;
    rdy_noise = 2'b10;
    issue(1'b0, 32'hC000_0044, 32'h0, 4'h0, 1'b1, 0, 3, t1);
    wait_idle();
    rdy_noise = 2'b00;

`ifdef AXI_IO_BRIDGE_TIMEOUT_EN
    // Timeout: ch0 never ready, abort after 64 WAIT cycles
    dly[0] = 0;
    issue(1'b0, 32'hC000_0050, 32'h0, 4'h0, 1'b1, 0, 0, t1);
    last_rdata = 32'hDEAD_BEEF;
    r.cyc = t1 + 66; r.wr = 1'b0; r.resp = 1'b1; r.rdata = last_rdata;
    rq.push_back(r);
    wait_idle();
    rdy_noise = 2'b01;
    repeat (3) @(negedge clk);
    rdy_noise = 2'b00;
    dly[0] = 2; rdv[0] = 32'h7777_0001;
    issue(1'b0, 32'hC000_0054, 32'h0, 4'h0, 1'b1, 0, 2, t1);
    wait_idle();
`endif

    // Reset during WAIT drops the transaction asynchronously
    dly[0] = 0;
    issue(1'b0, 32'hC000_0030, 32'h0, 4'h0, 1'b1, 0, 0, t1);
    t2 = 0;
    while (cyc < t1 + 2 && t2 < 10) begin
      t2++;
      @(negedge clk);
    end
    check("wait_io_addr", io_addr, 32'hC000_0030);
    rst_n = 1'b0;
    #1;
    check("arst_io_addr", io_addr, 0);
    check("arst_strobes", {io_addr_strobe, io_read_strobe, io_write_strobe}, 0);
    check("arst_valids", {bus.bvalid, bus.rvalid}, 0);
    check("arst_wready", bus.wready, 1);
    check("arst_rdata", bus.rdata, 0);
    last_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_wready", bus.wready, 1);
    repeat (6) @(negedge clk);

    // Clean transaction after reset
    dly[1] = 2; rdv[1] = 32'h2468_ACE0;
    issue(1'b0, 32'hC000_0110, 32'h0, 4'h0, 1'b1, 1, 2, t1);
    wait_idle();
    repeat (3) @(negedge clk);

    check("strobe_queue_empty", sq.size(), 0);
    check("resp_queue_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
